// File: rtl/array_r.sv
// Read-path array controller: opens a row, issues one CAS read per frame beat under
// FIFO credit, buffers in-order return data, then honours tRAS/tRTP before precharging.
module array_r #(
    parameter int ARRAY_ROW_ADDR   = 14,
    parameter int ARRAY_COL_ADDR   = 6,
    parameter int ARRAY_DATA_WIDTH = 64,
    parameter int FRAME_DATA_WIDTH = 3 + ARRAY_ROW_ADDR + ARRAY_COL_ADDR + ARRAY_DATA_WIDTH,
    parameter int RD_FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_rd_valid,
    input  logic [FRAME_DATA_WIDTH-1:0] frame_rd_data,
    output logic                        frame_rd_ready,
    output logic                        array_banksel_n,
    output logic [ARRAY_ROW_ADDR-1:0]   array_raddr,
    output logic                        array_cas_rd,
    output logic [ARRAY_COL_ADDR-1:0]   array_caddr_rd,
    input  logic                        array_rdata_vld,
    input  logic [ARRAY_DATA_WIDTH-1:0] array_rdata,
    output logic                        rd_data_valid,
    output logic [ARRAY_DATA_WIDTH-1:0] rd_data,
    output logic                        rd_data_last,
    input  logic                        rd_data_ready,
    output logic                        rd_end,
    input  logic [7:0]                  array_trcd_cfg,
    input  logic [7:0]                  array_trp_cfg,
    input  logic [7:0]                  array_tras_cfg,
    input  logic [7:0]                  array_trtp_cfg
);

    localparam int COL_LSB = ARRAY_DATA_WIDTH;
    localparam int ROW_LSB = COL_LSB + ARRAY_COL_ADDR;
    localparam int RW_BIT  = ROW_LSB + ARRAY_ROW_ADDR;
    localparam int EOF_BIT = RW_BIT + 1;
    localparam int SOF_BIT = RW_BIT + 2;
    localparam int PTR_W   = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(RD_FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_SRADDR,
        RD_RCD,
        RD_SEND,
        RD_WAIT,
        RD_RP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                      frame_sof;
    logic                      frame_eof;
    logic [ARRAY_ROW_ADDR-1:0] frame_row;
    logic [ARRAY_COL_ADDR-1:0] frame_col;
    logic                      unused_frame_bits;

    logic                      frame_fire;
    logic                      start;
    logic                      beat_load;
    logic                      beat_vld;
    logic                      beat_eof;
    logic [ARRAY_COL_ADDR-1:0] beat_col;
    logic                      last_issued;
    logic                      cas_issue;
    logic                      credit;
    logic                      wait_done;

    logic [7:0] trcd_m1;
    logic [7:0] trp_m1;
    logic [7:0] tras_m1;
    logic [7:0] trtp_m1;
    logic [7:0] phase_cnt;
    logic [7:0] tras_cnt;
    logic [7:0] trtp_cnt;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight_total;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             ret_push;
    logic             ret_last;
    logic             fifo_pop;
    logic [ARRAY_DATA_WIDTH:0] fifo_mem [RD_FIFO_DEPTH];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign frame_sof = frame_rd_data[SOF_BIT];
    assign frame_eof = frame_rd_data[EOF_BIT];
    assign frame_row = frame_rd_data[ROW_LSB +: ARRAY_ROW_ADDR];
    assign frame_col = frame_rd_data[COL_LSB +: ARRAY_COL_ADDR];
    assign unused_frame_bits = ^{frame_rd_data[RW_BIT], frame_rd_data[ARRAY_DATA_WIDTH-1:0]};

    // A zero timing value behaves like one cycle, so every wait compares against cfg-1.
    assign trcd_m1 = (array_trcd_cfg == 8'd0) ? 8'd0 : array_trcd_cfg - 8'd1;
    assign trp_m1  = (array_trp_cfg  == 8'd0) ? 8'd0 : array_trp_cfg  - 8'd1;
    assign tras_m1 = (array_tras_cfg == 8'd0) ? 8'd0 : array_tras_cfg - 8'd1;
    assign trtp_m1 = (array_trtp_cfg == 8'd0) ? 8'd0 : array_trtp_cfg - 8'd1;

    assign frame_fire     = frame_rd_valid && frame_rd_ready;
    assign start          = frame_fire && (state == IDLE) && frame_sof;
    assign beat_load      = frame_fire && ((state != IDLE) || frame_sof);
    assign inflight_total = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit         = inflight_total < DEPTH_W;
    assign wait_done      = (outstanding == '0) && (tras_cnt >= tras_m1) && (trtp_cnt >= trtp_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = RD_SRADDR;
            RD_SRADDR: state_nxt = RD_RCD;
            RD_RCD:    if (phase_cnt >= trcd_m1) state_nxt = RD_SEND;
            RD_SEND:   if (cas_issue && beat_eof) state_nxt = RD_WAIT;
            RD_WAIT:   if (wait_done) state_nxt = RD_RP;
            RD_RP:     if (phase_cnt >= trp_m1) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_rd_ready = 1'b0;
        cas_issue      = 1'b0;
        rd_end         = 1'b0;
        case (state)
            IDLE:    frame_rd_ready = 1'b1;
            RD_SEND: begin
                frame_rd_ready = !beat_vld && !last_issued;
                cas_issue      = beat_vld && credit;
            end
            RD_RP:   rd_end = (phase_cnt >= trp_m1);
            default: ;
        endcase
    end

    // The phase counter runs through SRADDR and RCD so CAS lands exactly tRCD after row open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= 8'd0;
            tras_cnt  <= 8'd0;
            trtp_cnt  <= 8'd0;
        end else begin
            case (state)
                RD_SRADDR, RD_RCD, RD_RP: phase_cnt <= sat_inc(phase_cnt);
                default:                  phase_cnt <= 8'd0;
            endcase
            if (state == RD_SRADDR)  tras_cnt <= 8'd0;
            else if (state != IDLE)  tras_cnt <= sat_inc(tras_cnt);
            if (cas_issue) trtp_cnt <= 8'd0;
            else           trtp_cnt <= sat_inc(trtp_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            array_banksel_n <= 1'b1;
            array_raddr     <= '0;
            array_cas_rd    <= 1'b0;
            array_caddr_rd  <= '0;
            beat_vld        <= 1'b0;
            beat_eof        <= 1'b0;
            beat_col        <= '0;
            last_issued     <= 1'b0;
        end else begin
            array_cas_rd <= cas_issue;
            if (cas_issue) array_caddr_rd <= beat_col;
            if (start) array_raddr <= frame_row;
            if (state == RD_SRADDR)                 array_banksel_n <= 1'b0;
            else if (state == RD_WAIT && wait_done) array_banksel_n <= 1'b1;
            if (beat_load) begin
                beat_vld <= 1'b1;
                beat_eof <= frame_eof;
                beat_col <= frame_col;
            end else if (cas_issue) begin
                beat_vld <= 1'b0;
            end
            if (start)                       last_issued <= 1'b0;
            else if (cas_issue && beat_eof)  last_issued <= 1'b1;
        end
    end

    // Returns are only credited against reads actually in flight; strays are dropped.
    assign ret_push = array_rdata_vld && (outstanding != '0);
    assign ret_last = last_issued && (outstanding == CNT_W'(1));
    assign fifo_pop = rd_data_valid && rd_data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            case ({cas_issue, ret_push})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            case ({ret_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (ret_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ret_push) fifo_mem[wr_ptr] <= {ret_last, array_rdata};
    end

    assign rd_data_valid = (fifo_count != '0);
    assign rd_data       = fifo_mem[rd_ptr][ARRAY_DATA_WIDTH-1:0];
    assign rd_data_last  = rd_data_valid && fifo_mem[rd_ptr][ARRAY_DATA_WIDTH];

endmodule

// File: tb/tb_array_r.sv
// Directed bench for array_r: a latency-configurable array model answers CAS reads,
// and each scenario task compares timing, addresses and returned beats inline.
module tb_array_r;

    localparam int ROW = 14;
    localparam int COL = 6;
    localparam int DW  = 64;
    localparam int FW  = 3 + ROW + COL + DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           frame_rd_valid = 1'b0;
    logic [FW-1:0]  frame_rd_data = '0;
    logic           frame_rd_ready;
    logic           array_banksel_n;
    logic [ROW-1:0] array_raddr;
    logic           array_cas_rd;
    logic [COL-1:0] array_caddr_rd;
    logic           array_rdata_vld = 1'b0;
    logic [DW-1:0]  array_rdata = '0;
    logic           rd_data_valid;
    logic [DW-1:0]  rd_data;
    logic           rd_data_last;
    logic           rd_data_ready = 1'b1;
    logic           rd_end;
    logic [7:0]     trcd = 8'd3;
    logic [7:0]     trp  = 8'd2;
    logic [7:0]     tras = 8'd4;
    logic [7:0]     trtp = 8'd2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 2;
    int acc_cyc = 0;

    logic           pv [8];
    logic [COL-1:0] pc [8];
    logic [ROW-1:0] pr [8];
    logic           prev_bs = 1'b1;
    int cas_cnt = 0;
    int fall_cnt = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int end_cnt = 0;
    int end_cyc = 0;
    logic [COL-1:0] cas_col_q [$];
    int             cas_cyc_q [$];
    logic [DW-1:0]  rx_data_q [$];
    logic           rx_last_q [$];

    always #5 clk = ~clk;

    array_r dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_rd_valid  (frame_rd_valid),
        .frame_rd_data   (frame_rd_data),
        .frame_rd_ready  (frame_rd_ready),
        .array_banksel_n (array_banksel_n),
        .array_raddr     (array_raddr),
        .array_cas_rd    (array_cas_rd),
        .array_caddr_rd  (array_caddr_rd),
        .array_rdata_vld (array_rdata_vld),
        .array_rdata     (array_rdata),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .rd_data_last    (rd_data_last),
        .rd_data_ready   (rd_data_ready),
        .rd_end          (rd_end),
        .array_trcd_cfg  (trcd),
        .array_trp_cfg   (trp),
        .array_tras_cfg  (tras),
        .array_trtp_cfg  (trtp)
    );

    function automatic logic [DW-1:0] mk_data(input logic [ROW-1:0] r, input logic [COL-1:0] c);
        return {16'hA5C3, 2'b00, r, 26'd0, c};
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Array model plus observers, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                pv[i] = 1'b0;
                pc[i] = '0;
                pr[i] = '0;
            end
            array_rdata_vld = 1'b0;
            array_rdata = '0;
            prev_bs = 1'b1;
        end else begin
            for (int i = 7; i > 0; i--) begin
                pv[i] = pv[i-1];
                pc[i] = pc[i-1];
                pr[i] = pr[i-1];
            end
            pv[0] = array_cas_rd;
            pc[0] = array_caddr_rd;
            pr[0] = array_raddr;
            array_rdata_vld = pv[lat-1];
            array_rdata = pv[lat-1] ? mk_data(pr[lat-1], pc[lat-1]) : '0;
            if (array_cas_rd) begin
                cas_cnt++;
                cas_col_q.push_back(array_caddr_rd);
                cas_cyc_q.push_back(cyc);
            end
            if (prev_bs && !array_banksel_n) begin
                fall_cnt++;
                fall_cyc = cyc;
            end
            if (!prev_bs && array_banksel_n) rise_cyc = cyc;
            prev_bs = array_banksel_n;
            if (rd_end) begin
                end_cnt++;
                end_cyc = cyc;
            end
            if (rd_data_valid && rd_data_ready) begin
                rx_data_q.push_back(rd_data);
                rx_last_q.push_back(rd_data_last);
            end
        end
    end

    task automatic clear_obs();
        cas_col_q.delete();
        cas_cyc_q.delete();
        rx_data_q.delete();
        rx_last_q.delete();
        cas_cnt = 0;
        fall_cnt = 0;
        end_cnt = 0;
    endtask

    task automatic send_frame(input logic sof, input logic eof, input logic [ROW-1:0] row,
                              input logic [COL-1:0] col);
        bit got = 1'b0;
        frame_rd_data  = {sof, eof, 1'b1, row, col, 64'hFEED_FACE_0000_0000};
        frame_rd_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (frame_rd_ready) begin
                got = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        frame_rd_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL frame_accept: ready never seen for col %0d, required within 300 cycles", col);
        end
    endtask

    task automatic wait_idle(input int beats, input int ends);
        int n = 0;
        while ((rx_data_q.size() < beats || end_cnt < ends) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("[TB] FAIL completion_timeout: beats=%0d ends=%0d, required beats=%0d ends=%0d",
                     rx_data_q.size(), end_cnt, beats, ends);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (array_banksel_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_banksel_n: got %b required 1", array_banksel_n); end
        checks++; if (array_raddr !== '0) begin failures++; $display("[TB] FAIL reset_raddr: got %h required 0", array_raddr); end
        checks++; if (array_cas_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_cas_rd: got %b required 0", array_cas_rd); end
        checks++; if (array_caddr_rd !== '0) begin failures++; $display("[TB] FAIL reset_caddr: got %h required 0", array_caddr_rd); end
        checks++; if (rd_data_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %b required 0", rd_data_valid); end
        checks++; if (rd_end !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_end: got %b required 0", rd_end); end
        checks++; if (frame_rd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b required 1", frame_rd_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        int cas0;
        trcd = 8'd3; tras = 8'd4; trtp = 8'd2; trp = 8'd2; lat = 2;
        clear_obs();
        send_frame(1'b1, 1'b1, 14'h1234, 6'd9);
        wait_idle(1, 1);
        cas0 = (cas_cyc_q.size() > 0) ? cas_cyc_q[0] : -100;
        checks++; if (fall_cyc - acc_cyc != 2) begin failures++; $display("[TB] FAIL single_open_delay: got %0d required 2", fall_cyc - acc_cyc); end
        checks++; if (cas0 - fall_cyc != 3) begin failures++; $display("[TB] FAIL single_trcd: got %0d required 3", cas0 - fall_cyc); end
        checks++; if (cas_cnt != 1) begin failures++; $display("[TB] FAIL single_cas_count: got %0d required 1", cas_cnt); end
        checks++; if (array_caddr_rd !== 6'd9) begin failures++; $display("[TB] FAIL single_caddr: got %0d required 9", array_caddr_rd); end
        checks++; if (array_raddr !== 14'h1234) begin failures++; $display("[TB] FAIL single_raddr: got %h required 1234", array_raddr); end
        checks++; if (rx_data_q.size() != 1) begin failures++; $display("[TB] FAIL single_beats: got %0d required 1", rx_data_q.size()); end
        checks++; if (rx_data_q.size() > 0 && rx_data_q[0] !== mk_data(14'h1234, 6'd9)) begin failures++; $display("[TB] FAIL single_data: got %h required %h", rx_data_q[0], mk_data(14'h1234, 6'd9)); end
        checks++; if (rx_last_q.size() > 0 && rx_last_q[0] !== 1'b1) begin failures++; $display("[TB] FAIL single_last: got %b required 1", rx_last_q[0]); end
        checks++; if (end_cnt != 1) begin failures++; $display("[TB] FAIL single_rd_end_count: got %0d required 1", end_cnt); end
        checks++; if (end_cyc - rise_cyc != 1) begin failures++; $display("[TB] FAIL single_trp: got %0d required 1", end_cyc - rise_cyc); end
        checks++; if (array_banksel_n !== 1'b1) begin failures++; $display("[TB] FAIL single_closed: got %b required 1", array_banksel_n); end
    endtask

    task automatic test_burst4();
        logic [DW-1:0] got_d;
        logic          got_l;
        clear_obs();
        for (int i = 0; i < 4; i++) send_frame(i == 0, i == 3, 14'h0ABC, COL'(i));
        wait_idle(4, 1);
        checks++; if (cas_cnt != 4) begin failures++; $display("[TB] FAIL burst4_cas_count: got %0d required 4", cas_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= cas_col_q.size() || cas_col_q[i] !== COL'(i)) begin
                failures++; $display("[TB] FAIL burst4_caddr[%0d]: got %0d required %0d", i, (i < cas_col_q.size()) ? cas_col_q[i] : 6'h3F, i);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (i >= cas_cyc_q.size() || cas_cyc_q[i] - cas_cyc_q[i-1] != 2) begin
                failures++; $display("[TB] FAIL burst4_cas_spacing[%0d]: got %0d required 2", i, (i < cas_cyc_q.size()) ? cas_cyc_q[i] - cas_cyc_q[i-1] : -1);
            end
        end
        checks++; if (rx_data_q.size() != 4) begin failures++; $display("[TB] FAIL burst4_beats: got %0d required 4", rx_data_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got_d = (i < rx_data_q.size()) ? rx_data_q[i] : '0;
            got_l = (i < rx_last_q.size()) ? rx_last_q[i] : 1'bx;
            checks++; if (got_d !== mk_data(14'h0ABC, COL'(i))) begin failures++; $display("[TB] FAIL burst4_data[%0d]: got %h required %h", i, got_d, mk_data(14'h0ABC, COL'(i))); end
            checks++; if (got_l !== (i == 3)) begin failures++; $display("[TB] FAIL burst4_last[%0d]: got %b required %b", i, got_l, i == 3); end
        end
        checks++; if (end_cnt != 1) begin failures++; $display("[TB] FAIL burst4_rd_end: got %0d required 1", end_cnt); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] got_d;
        logic          got_l;
        clear_obs();
        rd_data_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_frame(i == 0, i == 7, 14'h2001, COL'(16 + i));
            end
            begin
                repeat (40) @(posedge clk);
                #1;
                checks++; if (cas_cnt != 4) begin failures++; $display("[TB] FAIL stall_cas_count: got %0d required 4", cas_cnt); end
                checks++; if (rd_data_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_fifo_valid: got %b required 1", rd_data_valid); end
                checks++; if (rd_data !== mk_data(14'h2001, 6'd16)) begin failures++; $display("[TB] FAIL stall_head: got %h required %h", rd_data, mk_data(14'h2001, 6'd16)); end
                rd_data_ready = 1'b1;
            end
        join
        wait_idle(8, 1);
        checks++; if (cas_cnt != 8) begin failures++; $display("[TB] FAIL stall_total_cas: got %0d required 8", cas_cnt); end
        checks++; if (rx_data_q.size() != 8) begin failures++; $display("[TB] FAIL stall_beats: got %0d required 8", rx_data_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got_d = (i < rx_data_q.size()) ? rx_data_q[i] : '0;
            got_l = (i < rx_last_q.size()) ? rx_last_q[i] : 1'bx;
            checks++; if (got_d !== mk_data(14'h2001, COL'(16 + i))) begin failures++; $display("[TB] FAIL stall_data[%0d]: got %h required %h", i, got_d, mk_data(14'h2001, COL'(16 + i))); end
            checks++; if (got_l !== (i == 7)) begin failures++; $display("[TB] FAIL stall_last[%0d]: got %b required %b", i, got_l, i == 7); end
        end
    endtask

    task automatic test_tras_hold();
        tras = 8'd20;
        clear_obs();
        send_frame(1'b1, 1'b1, 14'h0321, 6'd33);
        wait_idle(1, 1);
        checks++; if (rise_cyc - fall_cyc < 20) begin failures++; $display("[TB] FAIL tras_min_open: got %0d required >=20", rise_cyc - fall_cyc); end
        checks++; if (rise_cyc - fall_cyc > 21) begin failures++; $display("[TB] FAIL tras_max_open: got %0d required <=21", rise_cyc - fall_cyc); end
        checks++; if (rx_data_q.size() != 1 || rx_data_q[0] !== mk_data(14'h0321, 6'd33)) begin failures++; $display("[TB] FAIL tras_data: got %0d beats, required 1 beat %h", rx_data_q.size(), mk_data(14'h0321, 6'd33)); end
        checks++; if (end_cnt != 1) begin failures++; $display("[TB] FAIL tras_rd_end: got %0d required 1", end_cnt); end
        tras = 8'd4;
    endtask

    task automatic test_sof_drop();
        clear_obs();
        send_frame(1'b0, 1'b1, 14'h3FFF, 6'd7);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (cas_cnt != 0) begin failures++; $display("[TB] FAIL drop_cas: got %0d required 0", cas_cnt); end
        checks++; if (fall_cnt != 0) begin failures++; $display("[TB] FAIL drop_banksel: got %0d opens required 0", fall_cnt); end
        checks++; if (array_raddr !== 14'h0321) begin failures++; $display("[TB] FAIL drop_raddr: got %h required 0321", array_raddr); end
        checks++; if (frame_rd_ready !== 1'b1) begin failures++; $display("[TB] FAIL drop_ready: got %b required 1", frame_rd_ready); end
        send_frame(1'b1, 1'b1, 14'h0155, 6'd12);
        wait_idle(1, 1);
        checks++; if (cas_cnt != 1) begin failures++; $display("[TB] FAIL drop_next_cas: got %0d required 1", cas_cnt); end
        checks++; if (rx_data_q.size() != 1 || rx_data_q[0] !== mk_data(14'h0155, 6'd12)) begin failures++; $display("[TB] FAIL drop_next_data: got %0d beats, required 1 beat %h", rx_data_q.size(), mk_data(14'h0155, 6'd12)); end
        checks++; if (rx_last_q.size() != 1 || rx_last_q[0] !== 1'b1) begin failures++; $display("[TB] FAIL drop_next_last: got %0d flags, required one set", rx_last_q.size()); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        rd_data_ready = 1'b0;
        send_frame(1'b1, 1'b0, 14'h0777, 6'd1);
        send_frame(1'b0, 1'b0, 14'h0000, 6'd2);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (cas_cnt != 2) begin failures++; $display("[TB] FAIL mid_cas_before_reset: got %0d required 2", cas_cnt); end
        checks++; if (rd_data_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_fifo_before_reset: got %b required 1", rd_data_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (array_banksel_n !== 1'b1) begin failures++; $display("[TB] FAIL mid_banksel_n: got %b required 1", array_banksel_n); end
        checks++; if (array_raddr !== '0) begin failures++; $display("[TB] FAIL mid_raddr: got %h required 0", array_raddr); end
        checks++; if (array_cas_rd !== 1'b0) begin failures++; $display("[TB] FAIL mid_cas_rd: got %b required 0", array_cas_rd); end
        checks++; if (array_caddr_rd !== '0) begin failures++; $display("[TB] FAIL mid_caddr: got %h required 0", array_caddr_rd); end
        checks++; if (rd_data_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rd_valid: got %b required 0", rd_data_valid); end
        checks++; if (frame_rd_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_ready: got %b required 1", frame_rd_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_data_ready = 1'b1;
        clear_obs();
        send_frame(1'b1, 1'b1, 14'h0999, 6'd40);
        wait_idle(1, 1);
        checks++; if (cas_cnt != 1 || array_caddr_rd !== 6'd40) begin failures++; $display("[TB] FAIL post_reset_cas: got %0d cas caddr %0d, required 1 cas caddr 40", cas_cnt, array_caddr_rd); end
        checks++; if (rx_data_q.size() != 1 || rx_data_q[0] !== mk_data(14'h0999, 6'd40)) begin failures++; $display("[TB] FAIL post_reset_data: got %0d beats, required 1 beat %h", rx_data_q.size(), mk_data(14'h0999, 6'd40)); end
        checks++; if (rx_last_q.size() != 1 || rx_last_q[0] !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_last: got %0d flags, required one set", rx_last_q.size()); end
        checks++; if (end_cnt != 1) begin failures++; $display("[TB] FAIL post_reset_rd_end: got %0d required 1", end_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst4();
        test_back_pressure();
        test_tras_hold();
        test_sof_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
